// File: rtl/cluster_rst_seq_pkg.sv
// Shared definitions for the cluster reset sequencer.
// State encoding and widths used by the FSM and the bench.
package cluster_rst_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_RST    = 3'd0,
    SEQ_RAMP   = 3'd1,
    SEQ_SETTLE = 3'd2,
    SEQ_RUN    = 3'd3,
    SEQ_WARM   = 3'd4,
    SEQ_DBG    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/rst_seq_cnt.sv
// Shared interval counter: clear wins over enable, done when
// cnt == limit-1 so a phase of N cycles ends on its Nth edge.
// Ports: clk, rst_n, clr, en, limit -> done.
module rst_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/cluster_rst_seq.sv
// Cold-boot clock ramp, global reset release and run-mode
// warm-reset / debug-init pulses for the cluster headers.
module cluster_rst_seq
  import cluster_rst_seq_pkg::*;
#(
  parameter int NUM_CLUSTERS = 4,
  parameter int STAGGER      = 2,
  parameter int RST_DLY      = 16,
  parameter int DBG_PULSE    = 4,
  parameter int CNT_W        = 8
) (
  input  logic                    gclk,
  input  logic                    arst_l,
  input  logic                    warm_rst_req,
  input  logic                    dbg_req,
  input  logic [NUM_CLUSTERS-1:0] cken_mask,
  output logic [NUM_CLUSTERS-1:0] cluster_cken,
  output logic                    grst_l,
  output logic                    gdbginit_l,
  output logic [SEQ_STATE_W-1:0]  seq_state,
  output logic                    seq_ready
);

  localparam int IDX_W =
    (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_CLUSTERS - 1);

  seq_state_e              state_q, state_d;
  logic [NUM_CLUSTERS-1:0] cken_en_q, cken_en_d;
  logic [NUM_CLUSTERS-1:0] cken_q, cken_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    grst_q, grst_d;
  logic                    dbgi_q, dbgi_d;
  logic                    ready_q, ready_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_lim;

  rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (gclk),
    .rst_n (arst_l),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_lim),
    .done  (cnt_done)
  );

  always_comb begin
    state_d   = state_q;
    cken_en_d = cken_en_q;
    idx_d     = idx_q;
    grst_d    = grst_q;
    dbgi_d    = dbgi_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cnt_lim   = CNT_W'(STAGGER);
    unique case (state_q)
      // The RST exit edge is the first ramp count cycle.
      SEQ_RST, SEQ_RAMP: begin
        state_d = SEQ_RAMP;
        cnt_lim = CNT_W'(STAGGER);
        if (cnt_done) begin
          cken_en_d[idx_q] = 1'b1;
          cnt_clr          = 1'b1;
          if (idx_q == LAST) begin
            state_d = SEQ_SETTLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      SEQ_SETTLE: begin
        cnt_lim = CNT_W'(RST_DLY);
        if (cnt_done) begin
          state_d = SEQ_RUN;
          grst_d  = 1'b1;
          dbgi_d  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SEQ_RUN: begin
        cnt_clr = 1'b1;
        if (warm_rst_req) begin
          state_d = SEQ_WARM;
          grst_d  = 1'b0;
        end else if (dbg_req) begin
          state_d = SEQ_DBG;
          dbgi_d  = 1'b0;
        end
      end
      SEQ_WARM: begin
        cnt_lim = CNT_W'(RST_DLY);
        if (warm_rst_req) begin
          cnt_clr = 1'b1;
        end else if (cnt_done) begin
          state_d = SEQ_RUN;
          grst_d  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SEQ_DBG: begin
        cnt_lim = CNT_W'(DBG_PULSE);
        if (warm_rst_req) begin
          state_d = SEQ_WARM;
          grst_d  = 1'b0;
          dbgi_d  = 1'b1;
          cnt_clr = 1'b1;
        end else if (cnt_done) begin
          state_d = SEQ_RUN;
          dbgi_d  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = SEQ_RST;
        cnt_clr = 1'b1;
      end
    endcase
    cken_d  = cken_en_d & cken_mask;
    ready_d = (state_d == SEQ_RUN);
  end

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q   <= SEQ_RST;
      cken_en_q <= '0;
      cken_q    <= '0;
      idx_q     <= '0;
      grst_q    <= 1'b0;
      dbgi_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cken_en_q <= cken_en_d;
      cken_q    <= cken_d;
      idx_q     <= idx_d;
      grst_q    <= grst_d;
      dbgi_q    <= dbgi_d;
      ready_q   <= ready_d;
    end
  end

  assign cluster_cken = cken_q;
  assign grst_l       = grst_q;
  assign gdbginit_l   = dbgi_q;
  assign seq_state    = state_q;
  assign seq_ready    = ready_q;

endmodule

// File: tb/tb_cluster_rst_seq.sv
// Bench for cluster_rst_seq: fixed vector table, corner
// sequences and random traffic against a timeline model.
module tb_cluster_rst_seq;

  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 16;
  localparam int P = 4;
  localparam int BOOT = N * S + D;

  logic         gclk = 1'b0;
  logic         arst_l;
  logic         warm_rst_req;
  logic         dbg_req;
  logic [N-1:0] cken_mask;
  logic [N-1:0] cluster_cken;
  logic         grst_l;
  logic         gdbginit_l;
  logic [2:0]   seq_state;
  logic         seq_ready;

  cluster_rst_seq #(
    .NUM_CLUSTERS(N), .STAGGER(S), .RST_DLY(D),
    .DBG_PULSE(P), .CNT_W(8)
  ) dut (
    .gclk         (gclk),
    .arst_l       (arst_l),
    .warm_rst_req (warm_rst_req),
    .dbg_req      (dbg_req),
    .cken_mask    (cken_mask),
    .cluster_cken (cluster_cken),
    .grst_l       (grst_l),
    .gdbginit_l   (gdbginit_l),
    .seq_state    (seq_state),
    .seq_ready    (seq_ready)
  );

  always #5 gclk = ~gclk;

  int vecs = 0;
  int miscompares = 0;

  // Model: cycles since reset release plus remaining pulse lengths.
  int         cyc;
  int         warm_left;
  int         dbg_left;
  logic [N-1:0] m_cken;
  logic       m_grst, m_dbgi;
  logic [2:0] m_st;

  function automatic void check(string tag, logic [N-1:0] ck,
                                logic g, logic d, logic [2:0] s);
    logic r;
    r = (s == 3'd3);
    vecs++;
    if (cluster_cken !== ck || grst_l !== g ||
        gdbginit_l !== d || seq_state !== s || seq_ready !== r) begin
      miscompares++;
      $display("FAIL %s t=%0d: got cken=%h grst=%b dbg=%b st=%0d rdy=%b, exp cken=%h grst=%b dbg=%b st=%0d rdy=%b",
               tag, cyc, cluster_cken, grst_l, gdbginit_l,
               seq_state, seq_ready, ck, g, d, s, r);
    end
  endfunction

  function automatic void model_reset();
    cyc = 0; warm_left = 0; dbg_left = 0;
    m_cken = '0; m_grst = 0; m_dbgi = 0; m_st = 3'd0;
  endfunction

  function automatic void model_step(bit w, bit d, logic [N-1:0] mk);
    logic [N-1:0] en;
    cyc++;
    for (int i = 0; i < N; i++) en[i] = (cyc >= (i + 1) * S);
    if (cyc < BOOT) begin
      m_grst = 0; m_dbgi = 0;
      m_st = (cyc < N * S) ? 3'd1 : 3'd2;
    end else begin
      if (cyc > BOOT) begin
        if (w) begin
          warm_left = D; dbg_left = 0;
        end else if (warm_left > 0) warm_left--;
        else if (dbg_left > 0) dbg_left--;
        else if (d) dbg_left = P;
      end
      m_grst = (warm_left == 0);
      m_dbgi = (dbg_left == 0);
      m_st = (warm_left > 0) ? 3'd4 : (dbg_left > 0) ? 3'd5 : 3'd3;
    end
    m_cken = en & mk;
  endfunction

  task automatic tick(bit w, bit d, logic [N-1:0] mk);
    warm_rst_req = w; dbg_req = d; cken_mask = mk;
    @(posedge gclk);
    model_step(w, d, mk);
    @(negedge gclk);
    check("model", m_cken, m_grst, m_dbgi, m_st);
  endtask

  task automatic do_reset();
    #2 arst_l = 1'b0;
    #1 check("async_rst", '0, 1'b0, 1'b0, 3'd0);
    model_reset();
    @(posedge gclk);
    @(negedge gclk);
    check("rst_hold", '0, 1'b0, 1'b0, 3'd0);
    arst_l = 1'b1;
  endtask

  typedef struct {
    int           n;
    bit           w;
    bit           d;
    logic [N-1:0] ck;
    logic         g;
    logic         dg;
    logic [2:0]   st;
  } vec_t;

  vec_t tbl[$];

  initial begin
    arst_l = 1'b0; warm_rst_req = 0; dbg_req = 0;
    cken_mask = '1;
    model_reset();
    repeat (2) @(negedge gclk);
    check("reset_vals", '0, 1'b0, 1'b0, 3'd0);
    arst_l = 1'b1;

    tbl = '{
      '{1, 0, 0, 4'h0, 0, 0, 3'd1},
      '{1, 0, 0, 4'h1, 0, 0, 3'd1},
      '{2, 0, 0, 4'h3, 0, 0, 3'd1},
      '{2, 0, 0, 4'h7, 0, 0, 3'd1},
      '{2, 0, 0, 4'hF, 0, 0, 3'd2},
      '{15, 0, 0, 4'hF, 0, 0, 3'd2},
      '{1, 0, 0, 4'hF, 1, 1, 3'd3},
      '{3, 0, 0, 4'hF, 1, 1, 3'd3},
      '{1, 1, 0, 4'hF, 0, 1, 3'd4},
      '{15, 0, 0, 4'hF, 0, 1, 3'd4},
      '{1, 0, 0, 4'hF, 1, 1, 3'd3},
      '{1, 0, 1, 4'hF, 1, 0, 3'd5},
      '{3, 0, 0, 4'hF, 1, 0, 3'd5},
      '{1, 0, 0, 4'hF, 1, 1, 3'd3},
      '{1, 1, 1, 4'hF, 0, 1, 3'd4},
      '{15, 0, 0, 4'hF, 0, 1, 3'd4},
      '{1, 0, 0, 4'hF, 1, 1, 3'd3},
      '{5, 0, 0, 4'hF, 1, 1, 3'd3}
    };
    foreach (tbl[k]) begin
      tick(tbl[k].w, tbl[k].d, 4'hF);
      for (int j = 1; j < tbl[k].n; j++) tick(0, 0, 4'hF);
      check($sformatf("tbl%0d", k), tbl[k].ck, tbl[k].g,
            tbl[k].dg, tbl[k].st);
    end

    // Debug pulse aborted by warm reset two cycles in.
    tick(0, 1, 4'hF);
    tick(0, 0, 4'hF);
    tick(1, 0, 4'hF);
    check("dbg_abort", 4'hF, 1'b0, 1'b1, 3'd4);
    repeat (15) tick(0, 0, 4'hF);
    check("abort_low", 4'hF, 1'b0, 1'b1, 3'd4);
    tick(0, 0, 4'hF);
    check("abort_end", 4'hF, 1'b1, 1'b1, 3'd3);

    // Boot with a partial mask, then open it.
    do_reset();
    for (int t = 1; t <= BOOT; t++) begin
      tick(0, 0, 4'b1010);
      if (t == 4) check("mask_t4", 4'h2, 1'b0, 1'b0, 3'd1);
      if (t == 8) check("mask_t8", 4'hA, 1'b0, 1'b0, 3'd2);
    end
    check("mask_boot", 4'hA, 1'b1, 1'b1, 3'd3);
    tick(0, 0, 4'hF);
    check("mask_open", 4'hF, 1'b1, 1'b1, 3'd3);

    // Reset mid-ramp, reboot with requests during SETTLE.
    do_reset();
    repeat (5) tick(0, 0, 4'hF);
    do_reset();
    for (int t = 1; t <= BOOT; t++)
      tick(t >= 10 && t <= 20 && t[0], t >= 10 && t <= 20 && !t[0], 4'hF);
    check("reboot", 4'hF, 1'b1, 1'b1, 3'd3);
    tick(0, 0, 4'hF);
    check("settle_ign", 4'hF, 1'b1, 1'b1, 3'd3);

    // Random traffic with occasional async resets.
    for (int r = 0; r < 1500; r++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      tick($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
           ($urandom_range(0, 7) == 0) ? N'($urandom) : 4'hF);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/cluster_rst_seq.md
Name: cluster_rst_seq

Overview:
- Chip-level clock/reset sequencer that sits directly upstream of the per-cluster clock headers.
- Drives each header's cluster_cken, grst_l and gdbginit_l inputs.
- After cold reset, enables cluster clocks one at a time (limits di/dt), waits for the clock synchronizers to settle, then releases grst_l and gdbginit_l together.
- In run mode it services warm-reset and debug-init requests with fixed-length low pulses.

Parameters:
- NUM_CLUSTERS, 4, number of cluster headers driven; must be >= 1.
- STAGGER, 2, gclk cycles between successive cluster clock enables; must be >= 1.
- RST_DLY, 16, gclk cycles grst_l stays low after the last enable, and the warm-reset pulse length; must be >= 1.
- DBG_PULSE, 4, gclk cycles gdbginit_l stays low for a debug init; must be >= 1.
- CNT_W, 8, internal counter width; must hold max(STAGGER, RST_DLY, DBG_PULSE).

Ports:
- gclk, input, 1, global clock.
- arst_l, input, 1, asynchronous active-low reset; deassertion is already synchronized upstream.
- warm_rst_req, input, 1, single-cycle warm reset request.
- dbg_req, input, 1, single-cycle debug-init request.
- cken_mask, input, NUM_CLUSTERS, per-cluster run-time clock gate; 1 = allowed.
- cluster_cken, output, NUM_CLUSTERS, per-cluster clock enable to the headers.
- grst_l, output, 1, synchronous global reset to the headers; active low.
- gdbginit_l, output, 1, synchronous debug init to the headers; active low.
- seq_state, output, 3, current FSM state encoding.
- seq_ready, output, 1, high only in RUN.

Behaviour:
- All outputs are registered. Reset values (arst_l=0): cluster_cken=0, grst_l=0, gdbginit_l=0, seq_state=RST, seq_ready=0, counter=0, enable index=0.
- States and encodings: RST=0, RAMP=1, SETTLE=2, RUN=3, WARM=4, DBG=5.
- Cycle counting: cycle 1 is the first gclk rising edge with arst_l high.
- RST: moves to RAMP on cycle 1.
- RAMP: the counter increments each cycle.
  - When it reaches STAGGER, set cken_en[idx]=1, clear the counter and increment idx.
  - After cken_en[NUM_CLUSTERS-1] is set, go to SETTLE with counter=0.
  - Result: cluster i enable rises on cycle (i+1)*STAGGER.
- SETTLE: counts RST_DLY cycles. The RUN transition, grst_l=1 and gdbginit_l=1 are all registered on the same edge, at cycle NUM_CLUSTERS*STAGGER+RST_DLY.
- cluster_cken = cken_en & cken_mask, registered. The mask applies in every state; a masked cluster does not stall the ramp (idx still advances).
- RUN:
  - warm_rst_req=1: go to WARM, grst_l=0 next cycle, counter=0.
  - Otherwise dbg_req=1: go to DBG, gdbginit_l=0 next cycle, counter=0.
  - Both in the same cycle: warm wins and dbg_req is dropped.
- WARM:
  - grst_l low for exactly RST_DLY cycles, then RUN with grst_l=1. cken_en is unchanged; clocks stay on.
  - warm_rst_req during WARM restarts the counter, so the pulse is extended.
  - dbg_req is ignored.
- DBG:
  - gdbginit_l low for exactly DBG_PULSE cycles, then RUN.
  - warm_rst_req during DBG aborts the pulse: gdbginit_l=1 and grst_l=0 on the same edge, state WARM, counter=0.
  - A repeated dbg_req is ignored.
- Requests in RST, RAMP or SETTLE are ignored and not queued.
- arst_l asserted at any time, including mid-RAMP, WARM or DBG, returns everything to reset values immediately (asynchronous). The full cold sequence reruns after deassertion.
- seq_ready = (state==RUN), registered together with the state.
- No output glitches: each output comes directly from a flop.

Decomposition:
- Shared package cluster_rst_seq_pkg holds:
  - state encoding constants SEQ_RST..SEQ_DBG (3 bits);
  - SEQ_STATE_W = 3.
- One sub-module, rst_seq_cnt: a CNT_W-bit counter with clear, enable and terminal-compare (cnt==limit-1 → done). It is shared by the RAMP, SETTLE, WARM and DBG timing.
- FSM, enable shift logic and output flops stay in cluster_rst_seq.

Test Plan:
- Cold boot, defaults, cken_mask=4'hF, no requests → cluster_cken bits rise at cycles 2, 4, 6, 8; grst_l, gdbginit_l and seq_ready rise at cycle 24; seq_state=3.
- In RUN, pulse warm_rst_req one cycle → grst_l low for exactly 16 cycles; cluster_cken stays 4'hF; gdbginit_l stays 1; seq_state 4 then 3.
- In RUN, pulse dbg_req → gdbginit_l low for exactly 4 cycles; grst_l stays 1. Then pulse warm_rst_req two cycles into DBG → gdbginit_l returns to 1 and grst_l drops on the same edge; grst_l low for 16 cycles.
- warm_rst_req and dbg_req asserted in the same RUN cycle → only the WARM pulse occurs; no gdbginit_l pulse follows.
- cken_mask=4'b1010 during boot → cluster_cken bit 1 rises at cycle 4 and bit 3 at cycle 8; bits 0 and 2 stay 0; grst_l still rises at 24. Then set the mask to 4'hF → all bits high one cycle later.
- Assert arst_l low at cycle 5 (mid-RAMP) → all outputs are 0 immediately. Release → the sequence restarts with the same cycle timing. Also check that requests pulsed during SETTLE are ignored.
